wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles spent waiting for load data.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  execute stage presents a retiring instruction.
REQ-007 in_ready  output  1  wb_stage accepts this cycle.
REQ-008 in_rd  input  ADDR_WIDTH  destination register.
REQ-009 in_wen  input  1  instruction writes rd.
REQ-010 in_is_load  input  1  result comes from LSU, not in_result.
REQ-011 in_result  input  DATA_WIDTH  ALU/CSR result for non-load instructions.
REQ-012 in_funct3  input  3  load type: LB=0, LH=1, LW=2, LBU=4, LHU=5.
REQ-013 in_addr_lo  input  2  load address bits [1:0].
REQ-014 lsu_rvalid  input  1  one-cycle pulse: lsu_rdata valid.
REQ-015 lsu_rdata  input  DATA_WIDTH  raw aligned word from memory.
REQ-016 Rw  output  ADDR_WIDTH  register file write index.
REQ-017 busW  output  DATA_WIDTH  register file write data.
REQ-018 Regwr  output  1  register file write enable.
REQ-019 commit  output  1  one-cycle pulse per retired instruction, including errored ones.
REQ-020 err  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout.

Function
REQ-021 SHALL implement FSM states IDLE, WAIT_LOAD, WRITE.
REQ-022 in_ready SHALL be 1 in IDLE and WRITE, and 0 in WAIT_LOAD.
REQ-023 Handshake: an instruction is accepted when in_valid && in_ready, and its fields are latched that cycle.
REQ-024 Accepted non-load: next state WRITE; Rw, busW, Regwr and commit are registered, so the write appears exactly 1 cycle after acceptance.
REQ-025 Accepted legal, aligned load: next state WAIT_LOAD; the watchdog counter is cleared to 0.
REQ-026 WAIT_LOAD: the counter increments each cycle; when lsu_rvalid is seen, next state is WRITE with busW equal to the extracted value.
REQ-027 Extraction: byte = rdata[8*addr_lo +: 8], half = rdata[16*addr_lo[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-028 Misaligned load (LH/LHU with addr_lo[0]=1; LW with addr_lo!=0) or illegal funct3 (3, 6, 7): no LSU wait; next state WRITE with Regwr=0, commit=1, err=1.
REQ-029 Timeout: if the counter reaches TIMEOUT without lsu_rvalid, next state WRITE with Regwr=0, commit=1, err=1.
REQ-030 Regwr = latched in_wen && latched rd != 0; Rw and busW are still driven when rd = 0.
REQ-031 In WRITE, the outputs are valid for exactly one cycle; a simultaneous acceptance yields back-to-back writes (1 instruction/cycle for non-loads).
REQ-032 WRITE with no acceptance: next state IDLE; Regwr, commit and err return to 0.
REQ-033 lsu_rvalid outside WAIT_LOAD (IDLE, WRITE, or the acceptance cycle) SHALL be ignored.
REQ-034 in_valid while in_ready=0 SHALL be ignored; the upstream stage holds its fields.

Reset
REQ-035 When rst=1 at posedge, the next state SHALL be IDLE, with Regwr=0, commit=0, err=0, Rw=0, busW=0 and the counter at 0.
REQ-036 Reset during WAIT_LOAD or WRITE SHALL abandon the instruction with no write and no commit, and a later lsu_rvalid is ignored.
REQ-037 rst SHALL take priority over any handshake in the same cycle.

Structure
REQ-038 Package wb_pkg SHALL hold the state enum and the funct3 load constants.
REQ-039 Sub-module load_extend (combinational: rdata, funct3, addr_lo -> data) SHALL perform extraction.
REQ-040 Outputs Rw, busW and Regwr SHALL connect directly to the register file write port.

Verification
REQ-041 ALU op rd=5, result 0x1234 accepted at cycle N -> at N+1: Regwr=1, Rw=5, busW=0x1234, commit=1.
REQ-042 LB at addr_lo=3, lsu_rdata 0x80FF_0000 after 4 cycles -> Regwr=1, busW=0xFFFF_FF80; in_ready=0 while waiting.
REQ-043 LHU at addr_lo=2, rdata 0xBEEF_0000 -> busW=0x0000_BEEF; LH at addr_lo=1 -> err=1, Regwr=0, commit=1, next cycle.
REQ-044 Three consecutive ALU ops, in_valid held high -> three consecutive Regwr cycles, with rd=0 producing Regwr=0 but commit=1.
REQ-045 Load with no lsu_rvalid -> after TIMEOUT cycles: err=1, commit=1, Regwr=0, then IDLE.
REQ-046 rst asserted in WAIT_LOAD, lsu_rvalid the following cycle -> no Regwr, no commit, state IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and load-type constants for the writeback stage.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // A load only waits on the LSU when its type is known and its address is naturally aligned.
    function automatic logic loadLegal(input logic [2:0] funct3, input logic [1:0] addrLo);
        logic ok;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~addrLo[0];
            F3_LW:         ok = (addrLo == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Upstream retire handshake, LSU return path and register file write port of the writeback stage.
interface wb_stage_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_wen;
    logic                  in_is_load;
    logic [DATA_WIDTH-1:0] in_result;
    logic [2:0]            in_funct3;
    logic [1:0]            in_addr_lo;
    logic                  lsu_rvalid;
    logic [DATA_WIDTH-1:0] lsu_rdata;
    logic [ADDR_WIDTH-1:0] Rw;
    logic [DATA_WIDTH-1:0] busW;
    logic                  Regwr;
    logic                  commit;
    logic                  err;

    modport master (
        output in_valid, in_rd, in_wen, in_is_load, in_result, in_funct3, in_addr_lo,
        output lsu_rvalid, lsu_rdata,
        input  in_ready, Rw, busW, Regwr, commit, err
    );

    modport slave (
        input  in_valid, in_rd, in_wen, in_is_load, in_result, in_funct3, in_addr_lo,
        input  lsu_rvalid, lsu_rdata,
        output in_ready, Rw, busW, Regwr, commit, err
    );

endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of an aligned memory word and sign- or zero-extends it.
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = rdata[{addr_lo, 3'b000} +: 8];
        halfVal = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   data = {{(DATA_WIDTH-8){byteVal[7]}}, byteVal};
            F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, byteVal};
            F3_LH:   data = {{(DATA_WIDTH-16){halfVal[15]}}, halfVal};
            F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, halfVal};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and waits (with a watchdog) for load data from the LSU.
module wb_stage
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  wen_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addrLo_q;
    logic [ADDR_WIDTH-1:0] Rw_q;
    logic [DATA_WIDTH-1:0] busW_q;
    logic                  Regwr_q;
    logic                  commit_q;
    logic                  err_q;

    logic                  readyInt;
    logic                  accept;
    logic [DATA_WIDTH-1:0] loadData;

    assign readyInt = (state_q != WAIT_LOAD);
    assign accept   = bus.in_valid && readyInt;

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
        .rdata  (bus.lsu_rdata),
        .funct3 (funct3_q),
        .addr_lo(addrLo_q),
        .data   (loadData)
    );

    // Write-port outputs are pulses; they default low and are raised only on the cycle a result retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            funct3_q <= '0;
            addrLo_q <= '0;
            Rw_q     <= '0;
            busW_q   <= '0;
            Regwr_q  <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            Regwr_q  <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                WAIT_LOAD: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.lsu_rvalid) begin
                        state_q  <= WRITE;
                        Rw_q     <= rd_q;
                        busW_q   <= loadData;
                        Regwr_q  <= wen_q && (rd_q != '0);
                        commit_q <= 1'b1;
                    end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                        state_q  <= WRITE;
                        Rw_q     <= rd_q;
                        commit_q <= 1'b1;
                        err_q    <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        rd_q     <= bus.in_rd;
                        wen_q    <= bus.in_wen;
                        funct3_q <= bus.in_funct3;
                        addrLo_q <= bus.in_addr_lo;
                        if (!bus.in_is_load) begin
                            state_q  <= WRITE;
                            Rw_q     <= bus.in_rd;
                            busW_q   <= bus.in_result;
                            Regwr_q  <= bus.in_wen && (bus.in_rd != '0);
                            commit_q <= 1'b1;
                        end else if (!loadLegal(bus.in_funct3, bus.in_addr_lo)) begin
                            state_q  <= WRITE;
                            Rw_q     <= bus.in_rd;
                            commit_q <= 1'b1;
                            err_q    <= 1'b1;
                        end else begin
                            state_q <= WAIT_LOAD;
                            cnt_q   <= '0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready = readyInt;
    assign bus.Rw       = Rw_q;
    assign bus.busW     = busW_q;
    assign bus.Regwr    = Regwr_q;
    assign bus.commit   = commit_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level model of retire timing and load extraction.
module tb_wb_stage;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    logic          expReady, expRegwr, expCommit, expErr;
    logic [AW-1:0] expRw;
    logic [DW-1:0] expBusW;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: which result retires and with what value, derived from the load rules.
    function automatic bit refLegal(input logic [2:0] f3, input logic [1:0] lo);
        int f = int'(f3);
        int a = int'(lo);
        return (f == 0 || f == 4) || ((f == 1 || f == 5) && (a % 2 == 0)) || (f == 2 && a == 0);
    endfunction

    function automatic logic [DW-1:0] refLoad(input logic [2:0] f3, input logic [1:0] lo, input logic [DW-1:0] word);
        logic [7:0]  b = 8'(word >> (8 * int'(lo)));
        logic [15:0] h = 16'(word >> (16 * (int'(lo) / 2)));
        case (int'(f3))
            0:       return DW'(int'($signed(b)));
            1:       return DW'(int'($signed(h)));
            4:       return DW'(b);
            5:       return DW'(h);
            default: return word;
        endcase
    endfunction

    task automatic expectIdle(input logic ready);
        expReady  = ready;
        expRegwr  = 1'b0;
        expCommit = 1'b0;
        expErr    = 1'b0;
    endtask

    task automatic expectWrite(input logic [AW-1:0] rd, input logic wen, input logic [DW-1:0] data);
        expReady  = 1'b1;
        expCommit = 1'b1;
        expErr    = 1'b0;
        expRegwr  = wen && (rd != 0);
        expRw     = rd;
        expBusW   = data;
    endtask

    task automatic expectError();
        expReady  = 1'b1;
        expCommit = 1'b1;
        expErr    = 1'b1;
        expRegwr  = 1'b0;
    endtask

    task automatic checkCycle(input string tag);
        checkOutput({tag, ".in_ready"}, DW'(bus.in_ready), DW'(expReady));
        checkOutput({tag, ".Regwr"},    DW'(bus.Regwr),    DW'(expRegwr));
        checkOutput({tag, ".commit"},   DW'(bus.commit),   DW'(expCommit));
        checkOutput({tag, ".err"},      DW'(bus.err),      DW'(expErr));
        if (expCommit && !expErr) begin
            checkOutput({tag, ".Rw"},   DW'(bus.Rw), DW'(expRw));
            checkOutput({tag, ".busW"}, bus.busW,    expBusW);
        end
    endtask

    task automatic clearInputs();
        bus.in_valid   = 1'b0;
        bus.in_rd      = '0;
        bus.in_wen     = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_result  = '0;
        bus.in_funct3  = '0;
        bus.in_addr_lo = '0;
        bus.lsu_rvalid = 1'b0;
        bus.lsu_rdata  = '0;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.in_valid   = 1'b0;
            bus.lsu_rvalid = 1'($urandom % 2);
            bus.lsu_rdata  = $urandom;
            expectIdle(1'b1);
            tick();
            checkCycle(tag);
        end
        bus.lsu_rvalid = 1'b0;
    endtask

    // Presents one instruction while the stage is ready; rvDelay is the wait cycle carrying lsu_rvalid (beyond TO = none).
    task automatic applyStimulus(input string tag, input logic [AW-1:0] rd, input logic wen, input logic isLoad,
                                 input logic [DW-1:0] result, input logic [2:0] f3, input logic [1:0] lo,
                                 input int rvDelay, input logic [DW-1:0] word);
        bit waits = isLoad && refLegal(f3, lo);
        bus.in_valid   = 1'b1;
        bus.in_rd      = rd;
        bus.in_wen     = wen;
        bus.in_is_load = isLoad;
        bus.in_result  = result;
        bus.in_funct3  = f3;
        bus.in_addr_lo = lo;
        bus.lsu_rvalid = 1'($urandom % 2);
        bus.lsu_rdata  = $urandom;
        if (!isLoad)     expectWrite(rd, wen, result);
        else if (!waits) expectError();
        else             expectIdle(1'b0);
        tick();
        checkCycle({tag, ".acc"});
        if (waits) begin
            for (int k = 1; k <= TO; k++) begin
                bus.in_valid = 1'($urandom % 2);
                if (k == rvDelay) begin
                    bus.lsu_rvalid = 1'b1;
                    bus.lsu_rdata  = word;
                    expectWrite(rd, wen, refLoad(f3, lo, word));
                end else begin
                    bus.lsu_rvalid = 1'b0;
                    bus.lsu_rdata  = $urandom;
                    if (k == TO) expectError();
                    else         expectIdle(1'b0);
                end
                tick();
                checkCycle({tag, ".wait"});
                if (k == rvDelay) break;
            end
        end
        bus.in_valid   = 1'b0;
        bus.lsu_rvalid = 1'b0;
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        expectIdle(1'b1);
        tick();
        tick();
        checkCycle("reset");
        checkOutput("reset.Rw",   DW'(bus.Rw), '0);
        checkOutput("reset.busW", bus.busW,    '0);
        rst = 1'b0;
        idleCycles(1, "idle");

        applyStimulus("alu5", 5'd5, 1'b1, 1'b0, 32'h1234, 3'd0, 2'd0, 0, '0);
        idleCycles(1, "idle");
        applyStimulus("lb3", 5'd8, 1'b1, 1'b1, '0, 3'd0, 2'd3, 4, 32'h80FF_0000);
        applyStimulus("lhu2", 5'd9, 1'b1, 1'b1, '0, 3'd5, 2'd2, 2, 32'hBEEF_0000);
        applyStimulus("lhMis", 5'd10, 1'b1, 1'b1, '0, 3'd1, 2'd1, 1, '0);
        applyStimulus("lwMis", 5'd11, 1'b1, 1'b1, '0, 3'd2, 2'd2, 1, '0);
        applyStimulus("f3ill", 5'd12, 1'b1, 1'b1, '0, 3'd6, 2'd0, 1, '0);
        applyStimulus("b2b1", 5'd3, 1'b1, 1'b0, 32'hAAAA_0001, 3'd0, 2'd0, 0, '0);
        applyStimulus("b2b2", 5'd0, 1'b1, 1'b0, 32'hAAAA_0002, 3'd0, 2'd0, 0, '0);
        applyStimulus("b2b3", 5'd7, 1'b1, 1'b0, 32'hAAAA_0003, 3'd0, 2'd0, 0, '0);
        applyStimulus("lwLast", 5'd13, 1'b1, 1'b1, '0, 3'd2, 2'd0, TO, 32'h1357_9BDF);
        applyStimulus("tmo", 5'd14, 1'b1, 1'b1, '0, 3'd2, 2'd0, TO + 5, '0);
        idleCycles(2, "postTmo");

        // Reset in the middle of a load wait must drop the load and ignore the late data.
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_funct3 = 3'd2; bus.in_addr_lo = 2'd0;
        bus.in_rd = 5'd9; bus.in_wen = 1'b1;
        expectIdle(1'b0);
        tick();
        checkCycle("rstWait.acc");
        bus.in_valid = 1'b0;
        tick();
        checkCycle("rstWait.w1");
        rst = 1'b1;
        expectIdle(1'b1);
        tick();
        checkCycle("rstWait.rst");
        checkOutput("rstWait.Rw",   DW'(bus.Rw), '0);
        checkOutput("rstWait.busW", bus.busW,    '0);
        rst = 1'b0;
        bus.lsu_rvalid = 1'b1;
        bus.lsu_rdata  = 32'hDEAD_BEEF;
        tick();
        checkCycle("rstWait.late");
        idleCycles(1, "rstWait.idle");

        // Reset wins over a simultaneous handshake.
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_rd = 5'd4; bus.in_result = 32'h55;
        tick();
        checkCycle("rstPrio.rst");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        checkCycle("rstPrio.after");

        applyStimulus("rstWr", 5'd6, 1'b1, 1'b0, 32'h77, 3'd0, 2'd0, 0, '0);
        rst = 1'b1;
        expectIdle(1'b1);
        tick();
        checkCycle("rstWr.rst");
        rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] rd;
            if ($urandom % 4 == 0) idleCycles(int'($urandom_range(1, 3)), "randIdle");
            rd = AW'($urandom);
            if ($urandom % 6 == 0) rd = '0;
            applyStimulus("rand", rd, 1'($urandom % 4 != 0), 1'($urandom % 5 >= 2), $urandom,
                          3'($urandom), 2'($urandom), int'($urandom_range(1, TO + 3)), $urandom);
        end
        idleCycles(1, "final");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
